// File: rtl/down_count_timer_if.sv
// down_count_timer_if: control/status bundle for the down-count timer
// master drives load/load_val/start/stop/en; slave returns count/busy/done/zero
interface down_count_timer_if #(parameter int WIDTH = 12);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;
  modport master (output load, load_val, start, stop, en, input count, busy, done, zero);
  modport slave  (input load, load_val, start, stop, en, output count, busy, done, zero);
endinterface

// File: rtl/down_count_timer.sv
// down_count_timer: loadable down-counter/timer with done pulse and optional auto-reload
// clk, rst_n (async active-low); bus.load/load_val/start/stop/en in; bus.count/busy/done/zero out
module down_count_timer #(
  parameter int WIDTH       = 12,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  down_count_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] count_q, count_nx, reload_q, reload_nx;
  logic             done_q, done_nx;
  always_comb begin
    state_nx  = state;
    count_nx  = count_q;
    reload_nx = reload_q;
    done_nx   = 1'b0;
    if (bus.load) begin
      count_nx  = bus.load_val;
      reload_nx = bus.load_val;
      state_nx  = IDLE;
    end else begin
      case (state)
        IDLE: state_nx = (!bus.stop && bus.start && count_q != '0) ? RUN : IDLE;
        RUN: begin
          if (bus.stop) state_nx = IDLE;
          else if (bus.en && count_q > WIDTH'(1)) count_nx = count_q - WIDTH'(1);
          else if (bus.en && count_q == WIDTH'(1)) begin
            done_nx  = 1'b1;
            count_nx = AUTO_RELOAD ? reload_q : '0;
            state_nx = AUTO_RELOAD ? RUN : DONE;
          end
        end
        DONE: begin
          if (!bus.stop && bus.start && reload_q != '0) begin
            count_nx = reload_q;
            state_nx = RUN;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      count_q  <= count_nx;
      reload_q <= reload_nx;
      done_q   <= done_nx;
    end
  end
  assign bus.count = count_q;
  assign bus.busy  = (state == RUN);
  assign bus.done  = done_q;
  assign bus.zero  = (count_q == '0);
endmodule

// File: doc/down_count_timer.md
Name: down_count_timer

Overview:
- 12-bit loadable down-counter/timer, the counterpart to the enable-strobed up counter.
- Counts down from a loaded value by one on each `en` strobe while running.
- Signals terminal count with a one-cycle `done` pulse, then either stops or auto-reloads.
- Used as the programmable-interval timer beside the up counter, driven by the same single-cycle `en` strobes.

Parameters:
- WIDTH, 12, counter and load-value width in bits.
- AUTO_RELOAD, 0, 1 = on reaching 0, reload the stored value and keep running; 0 = stop in DONE.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  synchronous load strobe; captures load_val.
- load_val  input  WIDTH  value written to count and to the reload register on load.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting; holds count.
- en  input  1  count strobe; one decrement per cycle high while in RUN.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  high while in RUN.
- done  output  1  registered one-cycle pulse on terminal count.
- zero  output  1  combinational (count == 0).

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-low (`rst_n`).
- Reset (rst_n=0, any time, including mid-count): count=0, reload register=0, state=IDLE, busy=0, done=0. Reset takes effect immediately, without waiting for a clock edge.
- States: IDLE, RUN, DONE. busy = (state==RUN). done defaults to 0 every cycle unless set as below.
- Input priority per cycle: load > stop > start > en.
- load, any state: count<=load_val, reload<=load_val, state->IDLE, done=0. Concurrent stop/start/en are ignored that cycle.
- IDLE:
  - start with count!=0 -> RUN. No decrement in that same cycle, even if en=1.
  - start with count==0 -> ignored; stays IDLE.
  - en ignored.
- RUN:
  - stop -> IDLE; count holds; no decrement, even if en=1. A later start resumes from the held value.
  - en with count>1 -> count<=count-1.
  - en with count==1 and AUTO_RELOAD=0 -> count<=0, done<=1, state->DONE.
  - en with count==1 and AUTO_RELOAD=1 -> count<=reload, done<=1, stays RUN.
  - en low -> hold.
  - en held high continuously -> one decrement per cycle.
- DONE:
  - count=0, zero=1, busy=0.
  - start -> count<=reload, state->RUN (only if reload!=0; otherwise ignored).
  - load behaves as above; en ignored.
- Latency: count updates on the rising edge where en is sampled high. done is asserted in the cycle immediately after that edge, aligned with count reaching 0 (or reload).
- Arithmetic: unsigned, WIDTH bits. Count never decrements below 0; no wrap to 4095.
- load_val=0 with AUTO_RELOAD=1: start is ignored, so the timer cannot enter RUN.

Test Plan:
- Reset mid-run: load 5, start, two en strobes (count=3), pulse rst_n low asynchronously between edges -> count=0, busy=0, done=0 immediately; start then ignored because count=0.
- Basic countdown (AUTO_RELOAD=0): load 3, start, en strobe 1 cycle every 3 cycles -> count 3,2,1,0; single-cycle done with count=0; state DONE, busy=0, zero=1; further en strobes leave count at 0.
- Auto-reload (AUTO_RELOAD=1): load 2, start, en held high -> count 2,1,2,1,2…; done high for one cycle on every reload edge; busy stays 1.
- Pause/resume: load 10, start, 4 strobes (count=6), stop with en=1 same cycle -> count stays 6, busy=0; start, 6 strobes -> 0 with done.
- Priority: in RUN at count=7, assert load(load_val=100), stop, and en together -> count=100, IDLE, no done; start with en=1 same cycle -> RUN, count stays 100.
- Boundary: load 4095, start, en continuous -> reaches 0 after exactly 4095 cycles, done once, no wrap; load 1, start, one en -> immediate done, count=0.
